// File: rtl/period_meter.sv
// period_meter: measures the spacing between rising edges of an asynchronous
// event line in clk_i cycles and reports each period with a one-cycle strobe.
module period_meter #(
    parameter int WIDTH       = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pulse_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] period_o,
    output logic             valid_o,
    output logic             overflow_o,
    output logic             measuring_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_rise;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       w_cnt_nxt;
    logic [WIDTH-1:0]       r_period;
    logic [WIDTH-1:0]       w_period_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_overflow;
    logic                   w_overflow_nxt;
    logic                   r_measuring;

    // Synchronizer and history flop run regardless of enable_i, so enabling
    // while pulse_i is already high can never fabricate an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_i};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Next-state and datapath decode; enable low overrides every state.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_period_nxt   = r_period;
        w_valid_nxt    = 1'b0;
        w_overflow_nxt = r_overflow;
        if (!enable_i) begin
            w_state_nxt    = S_IDLE;
            w_cnt_nxt      = CNT_ZERO;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ARM;
                    w_cnt_nxt   = CNT_ZERO;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_state_nxt = S_MEASURE;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = CNT_ONE;
                    end else if (r_cnt == CNT_MAX) begin
                        // Caught one step before the counter would wrap.
                        w_overflow_nxt = 1'b1;
                        w_cnt_nxt      = CNT_ZERO;
                        w_state_nxt    = S_ARM;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= CNT_ZERO;
            r_period    <= CNT_ZERO;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_measuring <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_period    <= w_period_nxt;
            r_valid     <= w_valid_nxt;
            r_overflow  <= w_overflow_nxt;
            r_measuring <= (w_state_nxt == S_MEASURE);
        end
    end

    assign period_o    = r_period;
    assign valid_o     = r_valid;
    assign overflow_o  = r_overflow;
    assign measuring_o = r_measuring;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: a 28-bit and a 4-bit instance share stimulus and are
// compared every cycle against an edge-timestamp reference model.
module tb_period_meter;

    localparam longint LIM0 = 64'd268435455;
    localparam longint LIM1 = 64'd15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse = 1'b0;
    logic        enable = 1'b0;

    logic [27:0] p28;
    logic        v28, o28, m28;
    logic [3:0]  p4;
    logic        v4, o4, m4;

    int n_checks = 0;
    int n_err    = 0;

    period_meter #(.WIDTH(28), .SYNC_STAGES(2)) u_dut28 (
        .clk_i(clk), .rst_i(rst), .pulse_i(pulse), .enable_i(enable),
        .period_o(p28), .valid_o(v28), .overflow_o(o28), .measuring_o(m28)
    );

    period_meter #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .pulse_i(pulse), .enable_i(enable),
        .period_o(p4), .valid_o(v4), .overflow_o(o4), .measuring_o(m4)
    );

    always #5 clk = ~clk;

    // Reference model: edges are timestamped; a period is the difference of
    // two detected edge times, overflow when elapsed time reaches the limit.
    logic [2:0]  ph = 3'b000;
    longint      cyc = 0;
    logic        m_armed [2] = '{1'b0, 1'b0};
    logic        m_ref   [2] = '{1'b0, 1'b0};
    logic        m_valid [2] = '{1'b0, 1'b0};
    logic        m_ovf   [2] = '{1'b0, 1'b0};
    longint      m_t0    [2] = '{0, 0};
    logic [63:0] m_period[2] = '{64'd0, 64'd0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph  <= 3'b000;
            cyc <= 0;
            for (int i = 0; i < 2; i++) begin
                m_armed[i]  <= 1'b0;
                m_ref[i]    <= 1'b0;
                m_valid[i]  <= 1'b0;
                m_ovf[i]    <= 1'b0;
                m_t0[i]     <= 0;
                m_period[i] <= 64'd0;
            end
        end else begin
            ph  <= {ph[1:0], pulse};
            cyc <= cyc + 1;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] <= 1'b0;
                if (!enable) begin
                    m_armed[i] <= 1'b0;
                    m_ref[i]   <= 1'b0;
                    m_ovf[i]   <= 1'b0;
                end else if (!m_armed[i]) begin
                    m_armed[i] <= 1'b1;
                end else if (!m_ref[i]) begin
                    if (ph[1] && !ph[2]) begin
                        m_ref[i] <= 1'b1;
                        m_t0[i]  <= cyc;
                    end
                end else if (ph[1] && !ph[2]) begin
                    m_period[i] <= 64'(cyc - m_t0[i]);
                    m_valid[i]  <= 1'b1;
                    m_t0[i]     <= cyc;
                end else if ((cyc - m_t0[i]) == ((i == 0) ? LIM0 : LIM1)) begin
                    m_ovf[i] <= 1'b1;
                    m_ref[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("valid28",  64'(v28), 64'(m_valid[0]));
        chk("period28", 64'(p28), m_period[0]);
        chk("ovf28",    64'(o28), 64'(m_ovf[0]));
        chk("meas28",   64'(m28), 64'(m_ref[0]));
        chk("valid4",   64'(v4),  64'(m_valid[1]));
        chk("period4",  64'(p4),  m_period[1]);
        chk("ovf4",     64'(o4),  64'(m_ovf[1]));
        chk("meas4",    64'(m4),  64'(m_ref[1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_cyc(input int hi, input int lo);
        pulse = 1'b1;
        idle(hi);
        pulse = 1'b0;
        idle(lo);
    endtask

    initial begin
        idle(2);
        chk("reset_period28", 64'(p28), 64'd0);
        chk("reset_valid28",  64'(v28), 64'd0);
        rst    = 1'b0;
        enable = 1'b1;
        idle(3);

        // Steady 10-cycle train
        for (int i = 0; i < 6; i++) pulse_cyc(5, 5);
        chk("t1_period28", 64'(p28), 64'd10);
        chk("t1_period4",  64'(p4),  64'd10);

        // 15-cycle spacing fits 4 bits, 16 overflows, then 7-cycle spacing
        pulse_cyc(5, 10);
        pulse_cyc(5, 11);
        pulse_cyc(3, 4);
        pulse_cyc(3, 4);
        idle(3);
        chk("t2_period4", 64'(p4),  64'd7);
        chk("t2_ovf4",    64'(o4),  64'd1);
        chk("t2_ovf28",   64'(o28), 64'd0);
        chk("t2_period28", 64'(p28), 64'd7);

        // Minimum-period trains
        for (int i = 0; i < 4; i++) pulse_cyc(1, 1);
        chk("t3_period2", 64'(p28), 64'd2);
        for (int i = 0; i < 4; i++) pulse_cyc(1, 2);
        idle(3);
        chk("t3_period3", 64'(p28), 64'd3);
        chk("t3_period3_w4", 64'(p4), 64'd3);

        // Disable mid-measure, re-enable while pulse_i is high
        for (int i = 0; i < 3; i++) pulse_cyc(5, 5);
        pulse = 1'b1;
        idle(3);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(4);
        chk("t4_ovf4_cleared", 64'(o4),  64'd0);
        chk("t4_period_held",  64'(p28), 64'd10);
        pulse = 1'b0;
        idle(4);
        for (int i = 0; i < 3; i++) pulse_cyc(4, 4);

        // Detected edge coincides with enable falling
        pulse = 1'b1;
        idle(2);
        enable = 1'b0;
        tick();
        chk("t5_no_valid", 64'(v28), 64'd0);
        chk("t5_idle",     64'(m28), 64'd0);
        idle(2);
        pulse  = 1'b0;
        enable = 1'b1;
        idle(3);

        // Asynchronous reset during a measurement
        for (int i = 0; i < 4; i++) pulse_cyc(5, 5);
        pulse = 1'b1;
        idle(3);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_period28", 64'(p28), 64'd0);
        chk("t6_async_meas28",   64'(m28), 64'd0);
        chk("t6_async_period4",  64'(p4),  64'd0);
        chk("t6_async_ovf4",     64'(o4),  64'd0);
        tick();
        rst   = 1'b0;
        pulse = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) pulse_cyc(6, 6);
        idle(3);
        chk("t6_period12", 64'(p28), 64'd12);

        // Randomized trains with occasional enable drops
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                idle($urandom_range(1, 3));
                enable = 1'b1;
            end
            pulse_cyc($urandom_range(1, 12), $urandom_range(1, 12));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
